exe_mem_pipe_stage: RTL and testbench



---
 rtl/exe_mem_pipe_stage_pkg.sv | 24 ++
 rtl/exe_mem_pipe_stage_if.sv | 49 ++++
 rtl/pipe_skid_buffer.sv | 80 ++++++++
 rtl/exe_mem_pipe_stage.sv | 79 +++++++
 tb/tb_exe_mem_pipe_stage.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_mem_pipe_stage_pkg.sv
// Shared defaults, state type and bundle sizing for the EXE->MEM pipeline stage
// and the generic skid buffer it is built on.
package exe_mem_pipe_stage_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_PC_W   = 32;
  localparam int unsigned DEF_RD_W   = 5;
  localparam int unsigned DEF_STAT_W = 16;
  localparam int unsigned CTRL_W     = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skidState_e;

  // Packed bundle width; field order pc, regWE, dataWE, regSel, rd, dataA, dataB, aluOut.
  function automatic int unsigned bundleWidth(input int unsigned pcW,
                                              input int unsigned rdW,
                                              input int unsigned dataW);
    return pcW + CTRL_W + rdW + 3 * dataW;
  endfunction

endpackage

// File: rtl/exe_mem_pipe_stage_if.sv
// EXE->MEM handshake and bundle signals; master is the surrounding pipeline,
// slave is the pipe stage itself.
interface exe_mem_pipe_stage_if
  import exe_mem_pipe_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned PC_W   = DEF_PC_W,
  parameter int unsigned RD_W   = DEF_RD_W,
  parameter int unsigned STAT_W = DEF_STAT_W
);

  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   pc_exe;
  logic              registerWriteEnable_i;
  logic              dataWriteEnable_i;
  logic              regSelect_i;
  logic [RD_W-1:0]   rd_i;
  logic [DATA_W-1:0] dataA_i;
  logic [DATA_W-1:0] dataB_i;
  logic [DATA_W-1:0] aluOut_i;

  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   pc_mem;
  logic              registerWriteEnable_o;
  logic              dataWriteEnable_o;
  logic              regSelect_o;
  logic [RD_W-1:0]   rd_o;
  logic [DATA_W-1:0] dataA_o;
  logic [DATA_W-1:0] dataB_o;
  logic [DATA_W-1:0] aluOut_o;
  logic [STAT_W-1:0] stall_cycles;

  modport master (
    output in_valid, pc_exe, registerWriteEnable_i, dataWriteEnable_i, regSelect_i,
           rd_i, dataA_i, dataB_i, aluOut_i, out_ready,
    input  in_ready, out_valid, pc_mem, registerWriteEnable_o, dataWriteEnable_o,
           regSelect_o, rd_o, dataA_o, dataB_o, aluOut_o, stall_cycles
  );

  modport slave (
    input  in_valid, pc_exe, registerWriteEnable_i, dataWriteEnable_i, regSelect_i,
           rd_i, dataA_i, dataB_i, aluOut_i, out_ready,
    output in_ready, out_valid, pc_mem, registerWriteEnable_o, dataWriteEnable_o,
           regSelect_o, rd_o, dataA_o, dataB_o, aluOut_o, stall_cycles
  );

endinterface

// File: rtl/pipe_skid_buffer.sv
// Generic valid/ready pipeline register: 2-entry skid (registered in_ready) or a
// single entry whose in_ready looks through to outReady.
module pipe_skid_buffer
  import exe_mem_pipe_stage_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned SKID_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         inValid,
  output logic         inReady_c,
  input  logic [W-1:0] inData,
  output logic         outValid,
  input  logic         outReady,
  output logic [W-1:0] outData
);

  skidState_e   state, stateNext;
  logic [W-1:0] mData, mDataNext;
  logic [W-1:0] sData, sDataNext;
  logic         xferIn, xferOut;

  assign outValid  = (state != EMPTY);
  assign outData   = mData;
  assign inReady_c = !rst && ((SKID_EN != 0) ? (state != SKID)
                                             : ((state == EMPTY) || outReady));
  assign xferIn    = inValid & inReady_c;
  assign xferOut   = outValid & outReady;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      mData <= '0;
      sData <= '0;
    end else begin
      state <= stateNext;
      mData <= mDataNext;
      sData <= sDataNext;
    end
  end

  // Flush drops validity only; held data stays put so bubble outputs remain stable.
  always_comb begin
    stateNext = state;
    mDataNext = mData;
    sDataNext = sData;
    if (flush) begin
      stateNext = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (xferIn) begin
            stateNext = FULL;
            mDataNext = inData;
          end
        end
        FULL: begin
          if (xferIn && xferOut) begin
            mDataNext = inData;
          end else if (xferOut) begin
            stateNext = EMPTY;
          end else if (xferIn) begin
            stateNext = SKID;
            sDataNext = inData;
          end
        end
        SKID: begin
          if (xferOut) begin
            stateNext = FULL;
            mDataNext = sData;
          end
        end
        default: stateNext = EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/exe_mem_pipe_stage.sv
// Elastic EXE->MEM pipeline register: packs the EXE bundle through a skid buffer,
// gates write enables on bubbles and counts MEM-side stall cycles.
module exe_mem_pipe_stage
  import exe_mem_pipe_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned PC_W    = DEF_PC_W,
  parameter int unsigned RD_W    = DEF_RD_W,
  parameter int unsigned SKID_EN = 1,
  parameter int unsigned STAT_W  = DEF_STAT_W
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 flush,
  exe_mem_pipe_stage_if.slave bus
);

  localparam int unsigned BUNDLE_W = bundleWidth(PC_W, RD_W, DATA_W);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              regWE;
    logic              dataWE;
    logic              regSel;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] dataA;
    logic [DATA_W-1:0] dataB;
    logic [DATA_W-1:0] aluOut;
  } bundle_t;

  bundle_t           inB, outB;
  logic              outValid;
  logic [STAT_W-1:0] stallCnt;

  assign inB.pc     = bus.pc_exe;
  assign inB.regWE  = bus.registerWriteEnable_i;
  assign inB.dataWE = bus.dataWriteEnable_i;
  assign inB.regSel = bus.regSelect_i;
  assign inB.rd     = bus.rd_i;
  assign inB.dataA  = bus.dataA_i;
  assign inB.dataB  = bus.dataB_i;
  assign inB.aluOut = bus.aluOut_i;

  pipe_skid_buffer #(
    .W       (BUNDLE_W),
    .SKID_EN (SKID_EN)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .inValid   (bus.in_valid),
    .inReady_c (bus.in_ready),
    .inData    (inB),
    .outValid  (outValid),
    .outReady  (bus.out_ready),
    .outData   (outB)
  );

  // Saturating stall counter; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= '0;
    end else if (outValid && !bus.out_ready && (stallCnt != '1)) begin
      stallCnt <= stallCnt + STAT_W'(1);
    end
  end

  assign bus.out_valid             = outValid;
  assign bus.pc_mem                = outB.pc;
  assign bus.registerWriteEnable_o = outValid & outB.regWE;
  assign bus.dataWriteEnable_o     = outValid & outB.dataWE;
  assign bus.regSelect_o           = outB.regSel;
  assign bus.rd_o                  = outB.rd;
  assign bus.dataA_o               = outB.dataA;
  assign bus.dataB_o               = outB.dataB;
  assign bus.aluOut_o              = outB.aluOut;
  assign bus.stall_cycles          = stallCnt;

endmodule

// File: tb/tb_exe_mem_pipe_stage.sv
// Bench for exe_mem_pipe_stage: three configurations share one stimulus stream and
// are compared every cycle against a FIFO-level reference model.
module tb_exe_mem_pipe_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 32;
  localparam int unsigned RW = 5;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  exe_mem_pipe_stage_if #(.DATA_W(DW), .PC_W(PW), .RD_W(RW), .STAT_W(16)) ifA ();
  exe_mem_pipe_stage_if #(.DATA_W(DW), .PC_W(PW), .RD_W(RW), .STAT_W(4))  ifB ();
  exe_mem_pipe_stage_if #(.DATA_W(DW), .PC_W(PW), .RD_W(RW), .STAT_W(16)) ifC ();

  exe_mem_pipe_stage #(.DATA_W(DW), .PC_W(PW), .RD_W(RW), .SKID_EN(1), .STAT_W(16))
    dutA (.clk(clk), .rst(rst), .flush(flush), .bus(ifA));
  exe_mem_pipe_stage #(.DATA_W(DW), .PC_W(PW), .RD_W(RW), .SKID_EN(1), .STAT_W(4))
    dutB (.clk(clk), .rst(rst), .flush(flush), .bus(ifB));
  exe_mem_pipe_stage #(.DATA_W(DW), .PC_W(PW), .RD_W(RW), .SKID_EN(0), .STAT_W(16))
    dutC (.clk(clk), .rst(rst), .flush(flush), .bus(ifC));

  // B and C see exactly the inputs driven onto A.
  assign ifB.in_valid = ifA.in_valid;                           assign ifC.in_valid = ifA.in_valid;
  assign ifB.pc_exe = ifA.pc_exe;                               assign ifC.pc_exe = ifA.pc_exe;
  assign ifB.registerWriteEnable_i = ifA.registerWriteEnable_i; assign ifC.registerWriteEnable_i = ifA.registerWriteEnable_i;
  assign ifB.dataWriteEnable_i = ifA.dataWriteEnable_i;         assign ifC.dataWriteEnable_i = ifA.dataWriteEnable_i;
  assign ifB.regSelect_i = ifA.regSelect_i;                     assign ifC.regSelect_i = ifA.regSelect_i;
  assign ifB.rd_i = ifA.rd_i;                                   assign ifC.rd_i = ifA.rd_i;
  assign ifB.dataA_i = ifA.dataA_i;                             assign ifC.dataA_i = ifA.dataA_i;
  assign ifB.dataB_i = ifA.dataB_i;                             assign ifC.dataB_i = ifA.dataB_i;
  assign ifB.aluOut_i = ifA.aluOut_i;                           assign ifC.aluOut_i = ifA.aluOut_i;
  assign ifB.out_ready = ifA.out_ready;                         assign ifC.out_ready = ifA.out_ready;

  typedef struct packed {
    logic [31:0] pc;
    logic        rwe;
    logic        dwe;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu;
  } mb_t;

  // Reference model: per configuration an ordered list of held bundles (oldest first).
  mb_t         ent [3][2];
  mb_t         last [3];
  int          cnt [3];
  int unsigned stall [3];
  int unsigned statMax [3] = '{65535, 15, 65535};
  bit          skidMode [3] = '{1'b1, 1'b1, 1'b0};
  bit          chk = 1'b0;
  bit          lastAcc = 1'b0;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit expReady(input int c);
    if (rst) return 1'b0;
    if (skidMode[c]) return cnt[c] < 2;
    return (cnt[c] == 0) || (ifA.out_ready == 1'b1);
  endfunction

  initial begin
    mb_t inB;
    bit  ov, xi, xo;
    forever begin
      @(posedge clk);
      inB.pc  = ifA.pc_exe;    inB.rwe = ifA.registerWriteEnable_i;
      inB.dwe = ifA.dataWriteEnable_i; inB.rs = ifA.regSelect_i;
      inB.rd  = ifA.rd_i;      inB.a = ifA.dataA_i;
      inB.b   = ifA.dataB_i;   inB.alu = ifA.aluOut_i;
      for (int c = 0; c < 3; c++) begin
        if (rst) begin
          cnt[c] = 0; last[c] = '0; stall[c] = 0;
          if (c == 0) lastAcc = 1'b0;
        end else begin
          ov = cnt[c] > 0;
          xo = ov && (ifA.out_ready == 1'b1);
          xi = (ifA.in_valid == 1'b1) && expReady(c);
          if (ov && !ifA.out_ready && stall[c] < statMax[c]) stall[c]++;
          if (c == 0) lastAcc = xi;
          if (flush) begin
            cnt[c] = 0;
          end else begin
            if (xo) begin ent[c][0] = ent[c][1]; cnt[c]--; end
            if (xi) begin ent[c][cnt[c]] = inB; cnt[c]++; end
          end
          if (cnt[c] > 0) last[c] = ent[c][0];
        end
      end
      if (rst) chk = 1'b1;
    end
  end

  task automatic cmpChan(input int c, input string t, input logic ov, input logic ir,
                         input logic [31:0] pc, input logic rwe, input logic dwe, input logic rs,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] alu, input logic [31:0] st);
    bit eov;
    eov = cnt[c] > 0;
    check({t, ".out_valid"}, 32'(ov), 32'(eov));
    check({t, ".in_ready"}, 32'(ir), 32'(expReady(c)));
    check({t, ".pc_mem"}, pc, last[c].pc);
    check({t, ".regWE"}, 32'(rwe), 32'(eov & last[c].rwe));
    check({t, ".dataWE"}, 32'(dwe), 32'(eov & last[c].dwe));
    check({t, ".regSel"}, 32'(rs), 32'(last[c].rs));
    check({t, ".rd"}, 32'(rd), 32'(last[c].rd));
    check({t, ".dataA"}, a, last[c].a);
    check({t, ".dataB"}, b, last[c].b);
    check({t, ".aluOut"}, alu, last[c].alu);
    check({t, ".stall"}, st, stall[c]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk) begin
        cmpChan(0, "A", ifA.out_valid, ifA.in_ready, ifA.pc_mem, ifA.registerWriteEnable_o,
                ifA.dataWriteEnable_o, ifA.regSelect_o, ifA.rd_o, ifA.dataA_o, ifA.dataB_o,
                ifA.aluOut_o, 32'(ifA.stall_cycles));
        cmpChan(1, "B", ifB.out_valid, ifB.in_ready, ifB.pc_mem, ifB.registerWriteEnable_o,
                ifB.dataWriteEnable_o, ifB.regSelect_o, ifB.rd_o, ifB.dataA_o, ifB.dataB_o,
                ifB.aluOut_o, 32'(ifB.stall_cycles));
        cmpChan(2, "C", ifC.out_valid, ifC.in_ready, ifC.pc_mem, ifC.registerWriteEnable_o,
                ifC.dataWriteEnable_o, ifC.regSelect_o, ifC.rd_o, ifC.dataA_o, ifC.dataB_o,
                ifC.aluOut_o, 32'(ifC.stall_cycles));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic v, input logic [31:0] pc, input logic rwe, input logic dwe);
    ifA.in_valid = v;
    ifA.pc_exe = pc;
    ifA.registerWriteEnable_i = rwe;
    ifA.dataWriteEnable_i = dwe;
    ifA.regSelect_i = 1'($urandom);
    ifA.rd_i = 5'($urandom);
    ifA.dataA_i = $urandom;
    ifA.dataB_i = $urandom;
    ifA.aluOut_i = $urandom;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ifA.out_ready = 1'b0;
    setIn(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    check("rst_in_ready", 32'(ifA.in_ready), 32'h0);
    check("rst_out_valid", 32'(ifA.out_valid), 32'h0);
    check("rst_pc_mem", ifA.pc_mem, 32'h0);
    check("rst_stall", 32'(ifA.stall_cycles), 32'h0);
    tick();

    // Streaming at full throughput.
    rst = 1'b0; ifA.out_ready = 1'b1; setIn(1'b1, 32'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("stream_in_ready", 32'(ifA.in_ready), 32'h1);
    check("stream_ov_before", 32'(ifA.out_valid), 32'h0);
    tick(); setIn(1'b1, 32'h04, 1'b0, 1'b0);
    @(negedge clk);
    check("stream_ov", 32'(ifA.out_valid), 32'h1);
    check("stream_pc0", ifA.pc_mem, 32'h00);
    tick(); setIn(1'b1, 32'h08, 1'b0, 1'b0);
    @(negedge clk);
    check("stream_pc4", ifA.pc_mem, 32'h04);
    tick(); setIn(1'b0, 32'h08, 1'b0, 1'b0);
    @(negedge clk);
    check("stream_pc8", ifA.pc_mem, 32'h08);
    check("stream_stall", 32'(ifA.stall_cycles), 32'h0);
    tick();
    @(negedge clk);
    check("stream_drained", 32'(ifA.out_valid), 32'h0);

    // Back-pressure into the skid entry.
    ifA.out_ready = 1'b0; setIn(1'b1, 32'h10, 1'b0, 1'b0);
    tick(); setIn(1'b1, 32'h14, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_ready_1", 32'(ifA.in_ready), 32'h1);
    check("bp_pc_10", ifA.pc_mem, 32'h10);
    tick(); setIn(1'b0, 32'h14, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_ready_0", 32'(ifA.in_ready), 32'h0);
    check("bp_hold_10", ifA.pc_mem, 32'h10);
    tick(); tick(); ifA.out_ready = 1'b1;
    @(negedge clk);
    check("bp_stall3", 32'(ifA.stall_cycles), 32'h3);
    check("bp_first", ifA.pc_mem, 32'h10);
    tick();
    @(negedge clk);
    check("bp_second", ifA.pc_mem, 32'h14);
    check("bp_second_ov", 32'(ifA.out_valid), 32'h1);
    tick();
    @(negedge clk);
    check("bp_empty", 32'(ifA.out_valid), 32'h0);

    // Flush with both entries held and a competing input.
    ifA.out_ready = 1'b0; setIn(1'b1, 32'h20, 1'b1, 1'b1);
    tick(); setIn(1'b1, 32'h24, 1'b1, 1'b1);
    tick(); setIn(1'b1, 32'h28, 1'b1, 1'b1); flush = 1'b1;
    @(negedge clk);
    check("fl_skid_ready", 32'(ifA.in_ready), 32'h0);
    tick(); flush = 1'b0; setIn(1'b0, 32'h28, 1'b0, 1'b0);
    @(negedge clk);
    check("fl_ov", 32'(ifA.out_valid), 32'h0);
    check("fl_rwe", 32'(ifA.registerWriteEnable_o), 32'h0);
    check("fl_dwe", 32'(ifA.dataWriteEnable_o), 32'h0);
    check("fl_ready", 32'(ifA.in_ready), 32'h1);
    check("fl_pc_held", ifA.pc_mem, 32'h20);
    setIn(1'b1, 32'h30, 1'b1, 1'b1); flush = 1'b1;
    tick(); flush = 1'b0; setIn(1'b0, 32'h30, 1'b0, 1'b0);
    @(negedge clk);
    check("fl_drop_ov", 32'(ifA.out_valid), 32'h0);
    check("fl_drop_pc", ifA.pc_mem, 32'h20);

    // Write-enable gating across a bubble.
    setIn(1'b1, 32'h40, 1'b1, 1'b1);
    tick(); setIn(1'b0, 32'h40, 1'b0, 1'b0); ifA.out_ready = 1'b1;
    @(negedge clk);
    check("bub_rwe1", 32'(ifA.registerWriteEnable_o), 32'h1);
    check("bub_dwe1", 32'(ifA.dataWriteEnable_o), 32'h1);
    tick();
    @(negedge clk);
    check("bub_rwe0", 32'(ifA.registerWriteEnable_o), 32'h0);
    check("bub_dwe0", 32'(ifA.dataWriteEnable_o), 32'h0);
    check("bub_pc_held", ifA.pc_mem, 32'h40);

    // Long stall: 4-bit counter saturates, 16-bit keeps counting.
    ifA.out_ready = 1'b0; setIn(1'b1, 32'h50, 1'b0, 1'b0);
    tick(); setIn(1'b0, 32'h50, 1'b0, 1'b0);
    repeat (20) tick();
    @(negedge clk);
    check("sat_A_25", 32'(ifA.stall_cycles), 32'd25);
    check("sat_B_15", 32'(ifB.stall_cycles), 32'd15);
    check("noskid_ready0", 32'(ifC.in_ready), 32'h0);
    check("skid_ready1", 32'(ifA.in_ready), 32'h1);
    ifA.out_ready = 1'b1;
    #1;
    check("noskid_ready_comb", 32'(ifC.in_ready), 32'h1);
    tick();

    // Reset while holding two entries under back-pressure.
    ifA.out_ready = 1'b0; setIn(1'b1, 32'h60, 1'b1, 1'b0);
    tick(); setIn(1'b1, 32'h64, 1'b0, 1'b1);
    tick(); rst = 1'b1;
    #1;
    check("mrst_ready_comb", 32'(ifA.in_ready), 32'h0);
    tick();
    @(negedge clk);
    check("mrst_ov", 32'(ifA.out_valid), 32'h0);
    check("mrst_pc", ifA.pc_mem, 32'h0);
    check("mrst_alu", ifA.aluOut_o, 32'h0);
    check("mrst_stall", 32'(ifA.stall_cycles), 32'h0);
    check("mrst_ready", 32'(ifA.in_ready), 32'h0);
    rst = 1'b0; setIn(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("mrst_release", 32'(ifA.in_ready), 32'h1);

    // Randomized traffic; an unaccepted bundle is held until taken.
    for (int i = 0; i < 2000; i++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 39) == 0);
      ifA.out_ready = ($urandom_range(0, 9) < 7);
      if (!(ifA.in_valid && !lastAcc))
        setIn($urandom_range(0, 3) != 0, $urandom, 1'($urandom), 1'($urandom));
    end
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
